// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS datapath: widths, special
// register indices, stack-top reset value and write-address select codes.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] SP   = 5'd29;
    localparam logic [ADDR_W-1:0] RA   = 5'd31;

    localparam logic [DATA_W-1:0] SP_RESET = 32'd227;

    // Destination-register select driven by the control unit
    typedef enum logic [1:0] {
        WSEL_RT = 2'b00,
        WSEL_SP = 2'b01,
        WSEL_RA = 2'b10,
        WSEL_RD = 2'b11
    } wsel_t;

endpackage

// File: rtl/registrador.sv
// Load-enable register with synchronous active-high reset; used for the
// A and B operand latches.
module registrador
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset clears, load captures, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/banco_reg_ab.sv
// General-purpose register bank with write-through bypass on both read
// ports, plus the A/B operand latches that capture the bypassed values.
module banco_reg_ab
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int SP_INDEX = 29,
    parameter int SP_RESET = 227,
    parameter int RA_INDEX = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic              LoadAB,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // Stack pointer starts at stack top; return address and the rest start cleared
    function automatic logic [DATA_W-1:0] reset_value(input int idx);
        if (idx == SP_INDEX) begin
            return DATA_W'(SP_RESET);
        end else if (idx == RA_INDEX) begin
            return '0;
        end else begin
            return '0;
        end
    endfunction

    // Bank storage: reset restores initial contents, writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= reset_value(i);
            end
        end else if (RegWrite && (WriteReg != ZERO)) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Read ports: $0 forced to zero, pending write forwarded ahead of storage
    always_comb begin
        ReadData1 = regs[ReadRegToIdx(ReadReg1)];
        ReadData2 = regs[ReadRegToIdx(ReadReg2)];
        if (ReadReg1 == ZERO) begin
            ReadData1 = '0;
        end else if (RegWrite && (WriteReg == ReadReg1)) begin
            ReadData1 = WriteData;
        end
        if (ReadReg2 == ZERO) begin
            ReadData2 = '0;
        end else if (RegWrite && (WriteReg == ReadReg2)) begin
            ReadData2 = WriteData;
        end
    end

    function automatic logic [ADDR_W-1:0] ReadRegToIdx(input logic [ADDR_W-1:0] idx);
        return idx;
    endfunction

    registrador #(.WIDTH(DATA_W)) u_reg_a (
        .clk   (clk),
        .reset (reset),
        .load  (LoadAB),
        .d     (ReadData1),
        .q     (A)
    );

    registrador #(.WIDTH(DATA_W)) u_reg_b (
        .clk   (clk),
        .reset (reset),
        .load  (LoadAB),
        .d     (ReadData2),
        .q     (B)
    );

endmodule

// File: tb/tb_banco_reg_ab.sv
// Directed self-checking bench for banco_reg_ab.
module tb_banco_reg_ab;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic        LoadAB;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] A;
    logic [31:0] B;

    int total = 0;
    int bad   = 0;

    banco_reg_ab dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .LoadAB    (LoadAB),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .A         (A),
        .B         (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        ReadReg1 = '0; ReadReg2 = '0; LoadAB = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        ReadReg1 = 5'd29; ReadReg2 = 5'd5;
        #1;
        check("rst_rd1_sp", ReadData1, 32'd227);
        check("rst_rd2_r5", ReadData2, 32'd0);
        check("rst_a", A, 32'd0);
        check("rst_b", B, 32'd0);
        ReadReg1 = 5'd31;
        #1;
        check("rst_rd1_ra", ReadData1, 32'd0);
        ReadReg1 = 5'd29;
        LoadAB = 1'b1;
        tick();
        LoadAB = 1'b0;
        check("load_a_sp", A, 32'd227);
        check("load_b_r5", B, 32'd0);

        // Write reg 8, bypass then storage
        RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd8;
        #1;
        check("bypass_rd1_r8", ReadData1, 32'hDEADBEEF);
        tick();
        RegWrite = 1'b0; WriteData = '0; ReadReg1 = 5'd8; ReadReg2 = 5'd8;
        #1;
        check("store_rd1_r8", ReadData1, 32'hDEADBEEF);
        check("store_rd2_r8", ReadData2, 32'hDEADBEEF);

        // Writes to $0 are dropped
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        check("zero_during_rd1", ReadData1, 32'd0);
        check("zero_during_rd2", ReadData2, 32'd0);
        tick();
        RegWrite = 1'b0;
        #1;
        check("zero_after_rd1", ReadData1, 32'd0);
        check("zero_after_rd2", ReadData2, 32'd0);

        // Write and load together: A sees new value
        RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'h00400010;
        ReadReg1 = 5'd31; ReadReg2 = 5'd8; LoadAB = 1'b1;
        #1;
        check("bypass_rd1_ra", ReadData1, 32'h00400010);
        tick();
        RegWrite = 1'b0; LoadAB = 1'b0; WriteData = '0;
        check("wl_a_ra", A, 32'h00400010);
        check("wl_b_r8", B, 32'hDEADBEEF);
        #1;
        check("store_rd1_ra", ReadData1, 32'h00400010);

        // Reset overrides write and load
        RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'h100;
        tick();
        RegWrite = 1'b0; ReadReg1 = 5'd29;
        #1;
        check("sp_written", ReadData1, 32'h100);
        reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'h55; LoadAB = 1'b1;
        tick();
        reset = 1'b0; RegWrite = 1'b0; LoadAB = 1'b0; WriteData = '0;
        ReadReg1 = 5'd29; ReadReg2 = 5'd8;
        #1;
        check("rst2_rd1_sp", ReadData1, 32'd227);
        check("rst2_rd2_r8", ReadData2, 32'd0);
        check("rst2_a", A, 32'd0);
        check("rst2_b", B, 32'd0);
        ReadReg1 = 5'd31;
        #1;
        check("rst2_rd1_ra", ReadData1, 32'd0);

        // A holds while source register changes
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'd7;
        tick();
        RegWrite = 1'b0; ReadReg1 = 5'd3; ReadReg2 = 5'd0; LoadAB = 1'b1;
        tick();
        LoadAB = 1'b0;
        check("hold_a_load7", A, 32'd7);
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'd9;
        tick();
        RegWrite = 1'b0;
        check("hold_a_stays7", A, 32'd7);
        #1;
        check("hold_rd1_9", ReadData1, 32'd9);
        tick();
        check("hold_a_still7", A, 32'd7);
        LoadAB = 1'b1;
        tick();
        LoadAB = 1'b0;
        check("hold_a_load9", A, 32'd9);
        check("hold_b_zero", B, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banco_reg_ab.md
# banco_reg_ab

General-purpose register bank for the multicycle MIPS datapath, plus the A/B operand latches. It receives the destination register index produced by the write-address select stage (rt, $29, $31 or rd), stores write-back data on the clock edge, and serves two read ports. The read ports feed the ALU operand path either directly or through the A/B latches. Register $0 always reads as zero. $29 (sp) comes out of reset at a fixed stack-top value.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (32 registers)
- SP_INDEX, 29, index of stack pointer
- SP_RESET, 227, reset value of SP_INDEX
- RA_INDEX, 31, index of return-address register (reset 0, no special write rule)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- RegWrite  in  1  write enable for the bank
- WriteReg  in  ADDR_W  destination index from write-address select
- WriteData  in  DATA_W  write-back value
- ReadReg1  in  ADDR_W  read port 1 index (instruction[25:21])
- ReadReg2  in  ADDR_W  read port 2 index (instruction[20:16])
- LoadAB  in  1  capture read-port values into A/B
- ReadData1  out  DATA_W  combinational read port 1
- ReadData2  out  DATA_W  combinational read port 2
- A  out  DATA_W  latched operand A
- B  out  DATA_W  latched operand B

## Operation
- Storage: 32 × DATA_W registers.
- Reset (reset=1 at edge):
  - all registers become 0, except reg[SP_INDEX] = SP_RESET.
  - A and B become 0.
  - Reset overrides RegWrite and LoadAB in the same cycle.
- Write: at the edge, if RegWrite=1 and WriteReg≠0, reg[WriteReg] ← WriteData. Writes to index 0 are discarded.
- Read ports, combinational:
  - ReadDataN = 0 if ReadRegN = 0.
  - Otherwise ReadDataN = WriteData if RegWrite=1 and WriteReg = ReadRegN (write-through bypass).
  - Otherwise ReadDataN = reg[ReadRegN].
  - Both ports may address the same register and return the same value.
- A/B latches: at the edge, if LoadAB=1, A ← ReadData1 and B ← ReadData2 (bypassed values). With LoadAB=0, A and B hold.
- No arithmetic; full DATA_W values pass through untouched. Indices are never out of range (5 bits cover all 32).

## Timing
- Write latency: 1 edge. The value is visible on the read ports combinationally in the write cycle (bypass), and from storage from the next cycle on.
- A/B latency: 1 edge after LoadAB.
- Write and LoadAB in the same cycle to the same index: A/B capture the new WriteData.
- Reset asserted mid-sequence: the next edge restores reset values. Any write or load presented in that cycle is lost.
- Reset outputs: ReadData1/2 follow reset register contents (0, or SP_RESET when the index is 29). A = B = 0.

## Structure
- Shared package (`mips_pkg`):
  - DATA_W and ADDR_W.
  - Register index constants: ZERO = 0, SP = 29, RA = 31.
  - SP_RESET = 227.
  - The 2-bit write-address select encodings: 00 rt, 01 $29, 10 $31, 11 rd.
  The write-address select stage and this block both consume these.
- One sub-module, `registrador`: a DATA_W load-enable register with synchronous reset. It is instantiated twice, for A and B.
- The bank array and the bypass logic live in the top module.

## Test plan
- Reset, then read with ReadReg1 = 29, ReadReg2 = 5 -> ReadData1 = 227, ReadData2 = 0. After LoadAB, A = 227, B = 0.
- Write 0xDEADBEEF to reg 8, next cycle ReadReg1 = 8 -> ReadData1 = 0xDEADBEEF. Same cycle with ReadReg2 = 8 -> ReadData2 = 0xDEADBEEF.
- RegWrite = 1, WriteReg = 0, WriteData = 0x12345678 -> ReadData for index 0 is 0 both during and after the write.
- Same cycle: RegWrite = 1, WriteReg = 31, WriteData = 0x00400010, ReadReg1 = 31, LoadAB = 1 -> A = 0x00400010 after the edge.
- Write reg 29 = 0x100, then assert reset together with RegWrite = 1, WriteReg = 29, WriteData = 0x55 -> reg 29 = 227 and A = B = 0 after the edge.
- LoadAB = 0 while reg 3 changes from 7 to 9, with A previously loaded from reg 3 -> A stays 7 until the next LoadAB, then becomes 9.
